// File: rtl/instruction_fetch_memory_pkg.sv
// Shared codes for the instruction fetch memory.
// Exception encodings, NOP word and the exception priority helper.
package instruction_fetch_memory_pkg;

    typedef enum logic [1:0] {
        IMEM_EXC_NONE     = 2'b00,
        IMEM_EXC_MISALIGN = 2'b01,
        IMEM_EXC_RANGE    = 2'b10
    } imem_exc_e;

    localparam logic [31:0] INSTR_NOP = 32'h0;

    function automatic imem_exc_e imem_exc(
        input logic misalign,
        input logic out_range
    );
        if (misalign) return IMEM_EXC_MISALIGN;
        if (out_range) return IMEM_EXC_RANGE;
        return IMEM_EXC_NONE;
    endfunction

endpackage

// File: rtl/instruction_fetch_memory_if.sv
// Fetch request / response handshake bundle.
// master = IF-stage PC logic, slave = instruction memory.
interface instruction_fetch_memory_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [1:0]            resp_exc;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid,
        input  resp_data, resp_addr, resp_exc
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid,
        output resp_data, resp_addr, resp_exc
    );
endinterface

// File: rtl/instruction_fetch_memory_resp_fifo.sv
// In-order response buffer with push/pop/clear.
// Pointers wrap naturally; occupancy is a separate counter.
module instruction_fetch_memory_resp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem_q[rd_ptr];
endmodule

// File: rtl/instruction_fetch_memory.sv
// Instruction ROM with valid/ready request and buffered in-order responses.
// ROM image is the fixed pattern word i = INIT_BASE + i.
module instruction_fetch_memory
    import instruction_fetch_memory_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    RESP_DEPTH  = 2,
    parameter logic [31:0]           INIT_BASE   = 32'h1000_0000
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic                      flush,
    instruction_fetch_memory_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int EW = 32 + ADDR_WIDTH + 2;
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);

    logic [31:0]           rom [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] offset;
    logic [IW-1:0]         idx;
    logic                  misalign;
    logic                  out_range;
    imem_exc_e             exc;
    logic [31:0]           data;
    logic                  acc;
    logic                  pop;
    logic                  full;
    logic [CW-1:0]         occ;
    logic [EW-1:0]         dout;

    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_rom
        assign rom[i] = INIT_BASE + 32'(i);
    end

    // Below-base addresses wrap to huge offsets and land out of range.
    assign offset    = bus.req_addr - BASE_ADDR;
    assign idx       = offset[IW+1:2];
    assign misalign  = |bus.req_addr[1:0];
    assign out_range = {1'b0, offset} >= LIMIT;
    assign exc       = imem_exc(misalign, out_range);
    assign data      = (exc == IMEM_EXC_NONE) ? rom[idx] : INSTR_NOP;

    assign bus.resp_valid = (occ != '0);
    assign full = (occ == CW'(RESP_DEPTH));
    assign pop  = bus.resp_valid & bus.resp_ready & ~flush;
    assign bus.req_ready = ~flush & (~full | pop);
    assign acc  = bus.req_valid & bus.req_ready;

    instruction_fetch_memory_resp_fifo #(
        .WIDTH(EW),
        .DEPTH(RESP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (acc),
        .pop   (pop),
        .clear (flush),
        .din   ({data, bus.req_addr, exc}),
        .dout  (dout),
        .count (occ)
    );

    assign {bus.resp_data, bus.resp_addr, bus.resp_exc} = dout;
endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench with a response scoreboard for instruction_fetch_memory.
module tb_instruction_fetch_memory;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  exc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush2 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    instruction_fetch_memory_if #(.ADDR_WIDTH(32)) bus ();
    instruction_fetch_memory_if #(.ADDR_WIDTH(32)) bus2 ();

    instruction_fetch_memory u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    instruction_fetch_memory #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h400)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush2),
        .bus   (bus2)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model(input logic [31:0] a);
        ent_t e;
        logic [31:0] off;
        off = a;
        e.addr = a;
        if (a[1:0] != 2'b00) begin
            e.exc = 2'b01;
            e.data = 32'h0;
        end else if (off >= 32'h1000) begin
            e.exc = 2'b10;
            e.data = 32'h0;
        end else begin
            e.exc = 2'b00;
            e.data = 32'h1000_0000 + (off >> 2);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (!flush && bus.resp_valid && bus.resp_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    ent_t e;
                    e = sb.pop_front();
                    check("sb_data", 64'(bus.resp_data), 64'(e.data));
                    check("sb_addr", 64'(bus.resp_addr), 64'(e.addr));
                    check("sb_exc", 64'(bus.resp_exc), 64'(e.exc));
                end
            end
            if (bus.req_valid && bus.req_ready)
                sb.push_back(model(bus.req_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ok = bus.req_ready;
            step();
            waited++;
            if (ok) break;
        end
        bus.req_valid = 1'b0;
        check("req_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 30; n++) begin
            if (sb.size() == 0) break;
            step();
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.resp_ready = 1'b0;
        bus2.req_valid = 1'b0;
        bus2.req_addr = '0;
        bus2.resp_ready = 1'b0;

        #12;
        check("rst_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_data", 64'(bus.resp_data), 64'd0);
        check("rst_addr", 64'(bus.resp_addr), 64'd0);
        check("rst_exc", 64'(bus.resp_exc), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // back-to-back stream
        bus.resp_ready = 1'b1;
        send(32'h0, w);
        check("t1_wait0", 64'(w), 64'd1);
        check("t1_data0", 64'(bus.resp_data), 64'h1000_0000);
        send(32'h4, w);
        check("t1_wait1", 64'(w), 64'd1);
        check("t1_data1", 64'(bus.resp_data), 64'h1000_0001);
        send(32'h8, w);
        check("t1_wait2", 64'(w), 64'd1);
        check("t1_data2", 64'(bus.resp_data), 64'h1000_0002);
        check("t1_exc", 64'(bus.resp_exc), 64'd0);
        step();
        check("t1_empty", 64'(bus.resp_valid), 64'd0);
        drain();

        // misaligned then in-order normal fetch
        send(32'h2, w);
        check("t2_exc", 64'(bus.resp_exc), 64'd1);
        check("t2_data", 64'(bus.resp_data), 64'd0);
        check("t2_addr", 64'(bus.resp_addr), 64'h2);
        send(32'h4, w);
        check("t2_next", 64'(bus.resp_data), 64'h1000_0001);
        drain();

        // out of range
        send(32'h1000, w);
        check("t3_exc", 64'(bus.resp_exc), 64'd2);
        check("t3_data", 64'(bus.resp_data), 64'd0);
        drain();

        bus2.resp_ready = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h3FC;
        #2;
        check("t3b_ready", 64'(bus2.req_ready), 64'd1);
        step();
        check("t3b_valid", 64'(bus2.resp_valid), 64'd1);
        check("t3b_exc", 64'(bus2.resp_exc), 64'd2);
        check("t3b_data", 64'(bus2.resp_data), 64'd0);
        bus2.req_addr = 32'h400;
        step();
        check("t3b_base", 64'(bus2.resp_data), 64'h1000_0000);
        check("t3b_bexc", 64'(bus2.resp_exc), 64'd0);
        bus2.req_addr = 32'h404;
        step();
        check("t3b_next", 64'(bus2.resp_data), 64'h1000_0001);
        bus2.req_valid = 1'b0;
        step();
        check("t3b_empty", 64'(bus2.resp_valid), 64'd0);

        // full buffer backpressure
        step();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h10;
        step();
        bus.req_addr = 32'h14;
        step();
        bus.req_addr = 32'h18;
        #2;
        check("t4_full0", 64'(bus.req_ready), 64'd0);
        step();
        check("t4_full1", 64'(bus.req_ready), 64'd0);
        check("t4_valid", 64'(bus.resp_valid), 64'd1);
        check("t4_head", 64'(bus.resp_addr), 64'h10);
        bus.resp_ready = 1'b1;
        #1;
        check("t4_comb", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 1'b0;
        check("t4_head2", 64'(bus.resp_addr), 64'h14);
        drain();

        // flush discards buffered entries
        bus.resp_ready = 1'b0;
        send(32'h20, w);
        send(32'h24, w);
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h28;
        #1;
        check("t5_ready", 64'(bus.req_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        sb.delete();
        check("t5_valid", 64'(bus.resp_valid), 64'd0);
        bus.resp_ready = 1'b1;
        send(32'h30, w);
        check("t5_own", 64'(bus.resp_addr), 64'h30);
        check("t5_data", 64'(bus.resp_data), 64'h1000_000C);
        drain();

        // asynchronous reset mid-operation
        bus.resp_ready = 1'b0;
        send(32'h40, w);
        send(32'h44, w);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_data", 64'(bus.resp_data), 64'd0);
        check("t6_exc", 64'(bus.resp_exc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        step();
        bus.req_valid = 1'b0;
        check("t6_rvalid", 64'(bus.resp_valid), 64'd1);
        check("t6_rdata", 64'(bus.resp_data), 64'h1000_0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
